// File: rtl/stoch_decode_mat.sv
// Matrix stochastic-to-binary decoder.
// Counts the ones on each row-major element stream over a window of
// 2^LOG_WIN clock cycles and presents all element counts together with a
// one-cycle valid strobe. One shared window counter sequences every element.
module stoch_decode_mat #(
    parameter int NUM_ROWS = 2,
    parameter int NUM_COLS = 2,
    parameter int LOG_WIN  = 8
) (
    input  logic                                      CLK,
    input  logic                                      nRST,
    input  logic                                      start,
    input  logic [NUM_ROWS*NUM_COLS-1:0]              Y,
    output logic [NUM_ROWS*NUM_COLS*(LOG_WIN+1)-1:0]  est,
    output logic                                      busy,
    output logic                                      valid
);

    localparam int N  = NUM_ROWS * NUM_COLS;
    localparam int CW = LOG_WIN + 1;

    // Terminal value of the window counter: the sample taken on this edge
    // is the last one of the window.
    localparam logic [LOG_WIN-1:0] WIN_LAST = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t              state;
    logic [LOG_WIN-1:0]  win_cnt_p0;
    logic [CW-1:0]       acc_p0 [N];

    // Adds one stream bit to an element count. CW bits hold the all-ones
    // window total 2^LOG_WIN, so no saturation is required.
    function automatic logic [CW-1:0] acc_add(input logic [CW-1:0] a,
                                              input logic          b);
        return a + {{(CW-1){1'b0}}, b};
    endfunction

    // Window FSM: clears accumulators on start, accumulates for 2^LOG_WIN
    // edges, then publishes every element count with a one-cycle strobe.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            win_cnt_p0 <= '0;
            for (int e = 0; e < N; e++) begin
                acc_p0[e] <= '0;
            end
            est   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Y is deliberately not sampled on the accepting edge.
                    if (start) begin
                        for (int e = 0; e < N; e++) begin
                            acc_p0[e] <= '0;
                        end
                        win_cnt_p0 <= '0;
                        busy       <= 1'b1;
                        state      <= COUNT;
                    end
                end
                COUNT: begin
                    // ---- stage p0: per-element accumulation ----
                    for (int e = 0; e < N; e++) begin
                        acc_p0[e] <= acc_add(acc_p0[e], Y[e]);
                    end
                    win_cnt_p0 <= win_cnt_p0 + 1'b1;
                    // ---- stage p1: publish, folding in the final sample ----
                    if (win_cnt_p0 == WIN_LAST) begin
                        for (int e = 0; e < N; e++) begin
                            est[e*CW +: CW] <= acc_add(acc_p0[e], Y[e]);
                        end
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_decode_mat.sv
// Directed bench for stoch_decode_mat: a 2x2 LOG_WIN=4 instance exercises
// packing, back-to-back windows, ignored starts and asynchronous reset; a
// 2x2 LOG_WIN=8 instance covers the full-scale count. Expected counts are
// pushed to per-instance queues when a window is driven and compared when
// the DUT raises valid.
module tb_stoch_decode_mat;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start4, start8;
    logic [3:0]  Y4, Y8;
    logic [19:0] est4;
    logic [35:0] est8;
    logic        busy4, valid4, busy8, valid8;

    always #5 CLK = ~CLK;

    stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .LOG_WIN(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .start(start4), .Y(Y4),
        .est(est4), .busy(busy4), .valid(valid4)
    );

    stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .LOG_WIN(8)) dut8 (
        .CLK(CLK), .nRST(nRST), .start(start8), .Y(Y8),
        .est(est8), .busy(busy8), .valid(valid8)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [35:0] est;
        int          at;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];
    exp_t m4, m8;

    logic [3:0] ypat [16];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference popcount of the 16-sample pattern for each element.
    function automatic logic [35:0] model4();
        logic [35:0] r;
        int          cnt;
        r = '0;
        for (int e = 0; e < 4; e++) begin
            cnt = 0;
            for (int t = 0; t < 16; t++) cnt += int'(ypat[t][e]);
            r[e*5 +: 5] = 5'(cnt);
        end
        return r;
    endfunction

    // Drives one LOG_WIN=4 window from ypat. hold keeps start high
    // throughout; mid (>=0) pulses start during that sample cycle.
    task automatic window4(input bit hold, input int mid);
        sb4.push_back('{est: model4(), at: cyc + 17});
        start4 = 1'b1;
        Y4     = 4'hF;           // must not be counted
        tick();
        for (int t = 0; t < 16; t++) begin
            start4 = hold ? 1'b1 : (t == mid);
            Y4     = ypat[t];
            check("busy4_in_window", busy4, 1);
            tick();
        end
        if (!hold) start4 = 1'b0;
    endtask

    task automatic window8(input logic [3:0] yv);
        logic [35:0] ex;
        for (int e = 0; e < 4; e++) ex[e*9 +: 9] = yv[e] ? 9'd256 : 9'd0;
        sb8.push_back('{est: ex, at: cyc + 257});
        start8 = 1'b1;
        Y8     = ~yv;
        tick();
        start8 = 1'b0;
        Y8     = yv;
        for (int t = 0; t < 256; t++) begin
            if (t == 128) check("busy8_mid", busy8, 1);
            tick();
        end
    endtask

    // Scoreboard for the LOG_WIN=4 instance.
    always @(negedge CLK) begin
        if (valid4 === 1'b1) begin
            if (sb4.size() == 0) begin
                check("valid4_unexpected", valid4, 0);
            end else begin
                m4 = sb4.pop_front();
                check("est4", est4, m4.est);
                check("valid4_latency", cyc, m4.at);
                check("busy4_at_valid", busy4, 0);
            end
        end else if (sb4.size() > 0 && cyc > sb4[0].at) begin
            m4 = sb4.pop_front();
            check("valid4_missing", valid4, 1);
        end
    end

    // Scoreboard for the LOG_WIN=8 instance.
    always @(negedge CLK) begin
        if (valid8 === 1'b1) begin
            if (sb8.size() == 0) begin
                check("valid8_unexpected", valid8, 0);
            end else begin
                m8 = sb8.pop_front();
                check("est8", est8, m8.est);
                check("valid8_latency", cyc, m8.at);
            end
        end else if (sb8.size() > 0 && cyc > sb8[0].at) begin
            m8 = sb8.pop_front();
            check("valid8_missing", valid8, 1);
        end
    end

    initial begin
        nRST   = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        Y4     = '0;
        Y8     = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_est4",   est4,   0);
        check("rst_busy4",  busy4,  0);
        check("rst_valid4", valid4, 0);
        check("rst_est8",   est8,   0);
        check("rst_busy8",  busy8,  0);
        check("rst_valid8", valid8, 0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // All-ones stream: full count on every element.
        for (int t = 0; t < 16; t++) ypat[t] = 4'hF;
        window4(0, -1);
        check("ones_est4", est4, {4{5'd16}});
        check("ones_valid4", valid4, 1);
        repeat (3) tick();

        // Distinct per-element patterns check the row-major packing.
        for (int t = 0; t < 16; t++)
            ypat[t] = {1'b1, (t % 4 == 0), (t % 2 == 0), 1'b0};
        window4(0, -1);
        check("pack_est4", est4, {5'd16, 5'd4, 5'd8, 5'd0});
        repeat (3) tick();

        // start held high: three back-to-back windows, 17 cycles apart.
        for (int w = 0; w < 3; w++) begin
            for (int t = 0; t < 16; t++) ypat[t] = 4'($urandom);
            window4(1, -1);
        end
        start4 = 1'b0;
        repeat (3) tick();

        // start pulsed mid-window is ignored.
        for (int t = 0; t < 16; t++) ypat[t] = 4'($urandom);
        window4(0, 8);
        repeat (3) tick();

        // Establish est=9, then abort a window with an asynchronous reset.
        for (int t = 0; t < 16; t++) ypat[t] = (t < 9) ? 4'hF : 4'h0;
        window4(0, -1);
        check("nine_est4", est4, {4{5'd9}});
        repeat (2) tick();
        start4 = 1'b1;
        Y4     = 4'hF;
        tick();
        start4 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            Y4 = 4'($urandom);
            tick();
        end
        #2;
        nRST = 1'b0;
        #1;
        check("abort_est4",   est4,   0);
        check("abort_busy4",  busy4,  0);
        check("abort_valid4", valid4, 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        repeat (20) tick();
        check("abort_est4_hold", est4, 0);
        check("abort_busy4_idle", busy4, 0);
        for (int t = 0; t < 16; t++) ypat[t] = 4'($urandom);
        window4(0, -1);
        repeat (3) tick();

        // Full-scale window: 256 without wrap, and all zeros.
        window8(4'hF);
        check("full_est8", est8, {4{9'd256}});
        repeat (3) tick();
        window8(4'h0);
        check("zero_est8", est8, 0);
        check("zero_valid8", valid8, 1);
        repeat (5) tick();

        check("sb4_drained", sb4.size(), 0);
        check("sb8_drained", sb8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
